// File: rtl/segre_pkg.sv
// Shared types and default geometry for the segre cache family.
// Cores and caches import this package to agree on memory-op encodings and address layout.
package segre_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        RF_REQ,
        RF_WAIT,
        RESPOND
    } assoc_cache_state_e;

    localparam int ASSOC_SETS       = 16;
    localparam int ASSOC_LINE_BYTES = 16;
    localparam int ASSOC_ADDR_W     = 32;

    localparam int OFFSET_W = $clog2(ASSOC_LINE_BYTES);
    localparam int INDEX_W  = $clog2(ASSOC_SETS);
    localparam int TAG_W    = ASSOC_ADDR_W - INDEX_W - OFFSET_W;

    // Byte lanes touched by an access of the given size, relative to its aligned offset.
    function automatic logic [3:0] dtype_byte_mask(memop_data_type_e dtype);
        case (dtype)
            BYTE:    return 4'b0001;
            HALF:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/segre_assoc_cache_way.sv
// One way of the set-associative cache: tag, valid, dirty and line storage for every set.
// Supports byte-enabled store writes and whole-line refills on the same indexed set.
module segre_assoc_cache_way
    import segre_pkg::*;
#(
    parameter int SETS       = ASSOC_SETS,
    parameter int LINE_BYTES = ASSOC_LINE_BYTES,
    parameter int IDX_W      = INDEX_W,
    parameter int TG_W       = TAG_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [IDX_W-1:0]        index,
    input  logic [TG_W-1:0]         tag,
    output logic                    hit,
    output logic                    valid,
    output logic                    dirty,
    output logic [TG_W-1:0]         line_tag,
    output logic [LINE_BYTES*8-1:0] line,
    input  logic                    be_we,
    input  logic [LINE_BYTES-1:0]   be,
    input  logic [LINE_BYTES*8-1:0] be_data,
    input  logic                    fill_we,
    input  logic [LINE_BYTES*8-1:0] fill_data,
    input  logic                    clr_dirty
);

    logic [SETS-1:0]         valid_q;
    logic [SETS-1:0]         dirty_q;
    logic [TG_W-1:0]         tag_q  [SETS];
    logic [LINE_BYTES*8-1:0] data_q [SETS];

    assign valid    = valid_q[index];
    assign dirty    = dirty_q[index];
    assign line_tag = tag_q[index];
    assign line     = data_q[index];
    assign hit      = valid_q[index] && (tag_q[index] == tag);

    // Only the state bits need reset; tags and data are qualified by valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (be_we) begin
            dirty_q[index] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_q[index] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            data_q[index] <= fill_data;
            tag_q[index]  <= tag;
        end else if (be_we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (be[b]) begin
                    data_q[index][b*8 +: 8] <= be_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/segre_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache with valid/ready handshakes.
// Holds the control FSM, round-robin victim pointers, store merge, load extract and memory muxing.
module segre_assoc_cache
    import segre_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  memop_data_type_e        req_dtype_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [DATA_W-1:0]       req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_we_o,
    output logic [ADDR_W-1:0]       mem_req_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_wline_o,
    input  logic                    mem_rsp_valid_i,
    input  logic [LINE_BYTES*8-1:0] mem_rline_i
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    assoc_cache_state_e state_q;

    logic                   req_we_q;
    memop_data_type_e       req_dtype_q;
    logic [ADDR_W-1:0]      req_addr_q;
    logic [DATA_W-1:0]      req_wdata_q;
    logic [WAY_W-1:0]       victim_q;
    logic                   victim_free_q;
    logic [WAY_W-1:0]       victim_ptr_q [SETS];

    logic [IDX_W-1:0]       req_index;
    logic [TG_W-1:0]        req_tag;
    logic [OFF_W-1:0]       req_off;
    logic [ADDR_W-1:0]      req_line_addr;

    logic [WAYS-1:0]        way_hit;
    logic [WAYS-1:0]        way_valid;
    logic [WAYS-1:0]        way_dirty;
    logic [TG_W-1:0]        way_tag  [WAYS];
    logic [LINE_W-1:0]      way_line [WAYS];

    logic                   any_hit;
    logic [WAY_W-1:0]       hit_way;
    logic                   free_found;
    logic [WAY_W-1:0]       free_way;
    logic [WAY_W-1:0]       victim_way;

    logic [LINE_BYTES-1:0]  store_be;
    logic [LINE_W-1:0]      store_line;
    logic [LINE_W-1:0]      hit_shifted;
    logic [DATA_W-1:0]      load_data;

    assign req_index     = req_addr_q[OFF_W +: IDX_W];
    assign req_tag       = req_addr_q[ADDR_W-1 -: TG_W];
    assign req_line_addr = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Sub-word accesses are forced onto their natural alignment.
    always_comb begin
        req_off = req_addr_q[OFF_W-1:0];
        case (req_dtype_q)
            HALF:    req_off[0]   = 1'b0;
            WORD:    req_off[1:0] = 2'b00;
            default: ;
        endcase
    end

    for (genvar g = 0; g < WAYS; g++) begin : gen_way
        segre_assoc_cache_way #(
            .SETS       (SETS),
            .LINE_BYTES (LINE_BYTES),
            .IDX_W      (IDX_W),
            .TG_W       (TG_W)
        ) u_way (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .index     (req_index),
            .tag       (req_tag),
            .hit       (way_hit[g]),
            .valid     (way_valid[g]),
            .dirty     (way_dirty[g]),
            .line_tag  (way_tag[g]),
            .line      (way_line[g]),
            .be_we     ((state_q == LOOKUP) && req_we_q && way_hit[g]),
            .be        (store_be),
            .be_data   (store_line),
            .fill_we   ((state_q == RF_WAIT) && mem_rsp_valid_i && (victim_q == WAY_W'(g))),
            .fill_data (mem_rline_i),
            .clr_dirty ((state_q == WB_REQ) && mem_req_ready_i && (victim_q == WAY_W'(g)))
        );
    end

    assign any_hit = |way_hit;

    // Victim choice prefers the lowest-index invalid way before rotating through full sets.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = WAY_W'(w);
        end
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
        victim_way = free_found ? free_way : victim_ptr_q[req_index];
    end

    assign store_be   = LINE_BYTES'(dtype_byte_mask(req_dtype_q)) << req_off;
    assign store_line = LINE_W'(req_wdata_q) << {req_off, 3'b000};

    always_comb begin
        hit_shifted = way_line[hit_way] >> {req_off, 3'b000};
        case (req_dtype_q)
            BYTE:    load_data = DATA_W'(hit_shifted[7:0]);
            HALF:    load_data = DATA_W'(hit_shifted[15:0]);
            default: load_data = hit_shifted[DATA_W-1:0];
        endcase
    end

    // Control FSM; all handshake outputs are registered and change only on state transitions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            req_ready_o     <= 1'b1;
            rsp_valid_o     <= 1'b0;
            rsp_rdata_o     <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_we_o    <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_wline_o     <= '0;
            req_we_q        <= 1'b0;
            req_dtype_q     <= WORD;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            victim_q        <= '0;
            victim_free_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                victim_ptr_q[s] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_we_q    <= req_we_i;
                        req_dtype_q <= req_dtype_i;
                        req_addr_q  <= req_addr_i;
                        req_wdata_q <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (any_hit) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= req_we_q ? '0 : load_data;
                        state_q     <= RESPOND;
                    end else begin
                        victim_q        <= victim_way;
                        victim_free_q   <= free_found;
                        mem_req_valid_o <= 1'b1;
                        if (way_dirty[victim_way]) begin
                            mem_req_we_o   <= 1'b1;
                            mem_req_addr_o <= {way_tag[victim_way], req_index, {OFF_W{1'b0}}};
                            mem_wline_o    <= way_line[victim_way];
                            state_q        <= WB_REQ;
                        end else begin
                            mem_req_we_o   <= 1'b0;
                            mem_req_addr_o <= req_line_addr;
                            state_q        <= RF_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_we_o   <= 1'b0;
                        mem_req_addr_o <= req_line_addr;
                        state_q        <= RF_REQ;
                    end
                end
                RF_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state_q         <= RF_WAIT;
                    end
                end
                RF_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (WAYS > 1 && !victim_free_q) begin
                            victim_ptr_q[req_index] <= victim_q + WAY_W'(1);
                        end
                        state_q <= LOOKUP;
                    end
                end
                RESPOND: begin
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= '0;
                    req_ready_o <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // A line may live in at most one way of a set.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     (state_q == LOOKUP) |-> $onehot0(way_hit));

endmodule

// File: tb/tb_segre_assoc_cache.sv
// Directed self-checking bench for segre_assoc_cache (WAYS=2, SETS=16, LINE_BYTES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_segre_assoc_cache;
    import segre_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_we_i = 1'b0;
    memop_data_type_e req_dtype_i = WORD;
    logic [31:0]      req_addr_i = '0;
    logic [31:0]      req_wdata_i = '0;
    logic             rsp_valid_o;
    logic [31:0]      rsp_rdata_o;
    logic             mem_req_valid_o;
    logic             mem_req_ready_i = 1'b0;
    logic             mem_req_we_o;
    logic [31:0]      mem_req_addr_o;
    logic [127:0]     mem_wline_o;
    logic             mem_rsp_valid_i = 1'b0;
    logic [127:0]     mem_rline_i = '0;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] L0  = 128'h33333333_22222222_DEADBEEF_11111111;
    localparam logic [127:0] WB0 = 128'h33333333_22222222_DEADABEF_11111111;
    localparam logic [127:0] L1  = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    localparam logic [127:0] WB1 = 128'hAAAA0003_12345678_AAAA0001_AAAA0000;
    localparam logic [127:0] L2  = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    localparam logic [127:0] L3  = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    localparam logic [127:0] L4  = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;

    always #5 clk_i = ~clk_i;

    segre_assoc_cache #(
        .WAYS(2), .SETS(16), .LINE_BYTES(16), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_dtype_i     (req_dtype_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_wline_o     (mem_wline_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rline_i     (mem_rline_i)
    );

    // Presents one request for a single accepting edge; returns on the lookup-cycle falling edge.
    task automatic issue(input logic we, input memop_data_type_e dt,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("[TB] FAIL issue_timeout: req_ready_o stayed %0b, required 1", req_ready_o);
        end
        req_we_i    = we;
        req_dtype_i = dt;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output logic [31:0] data, output int lat);
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        data = rsp_rdata_o;
        if (!rsp_valid_o) begin
            checks++; errors++;
            $display("[TB] FAIL %s_rsp_timeout: rsp_valid_o=%0b, required 1", name, rsp_valid_o);
        end
    endtask

    task automatic mem_accept(input string name, output logic we,
                              output logic [31:0] addr, output logic [127:0] wline);
        int n = 0;
        while (!mem_req_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!mem_req_valid_o) begin
            checks++; errors++;
            $display("[TB] FAIL %s_memreq_timeout: mem_req_valid_o=0, required 1", name);
        end
        we    = mem_req_we_o;
        addr  = mem_req_addr_o;
        wline = mem_wline_o;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
    endtask

    task automatic mem_return(input logic [127:0] line, input int delay);
        repeat (delay) @(negedge clk_i);
        mem_rline_i     = line;
        mem_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: valid=%0b data=%h, required 0/0", rsp_valid_o, rsp_rdata_o);
        end
        checks++;
        if (mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_memreq: got %0b, required 0", mem_req_valid_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %0b, required 1", req_ready_o);
        end
    endtask

    task automatic test_cold_load();
        logic we; logic [31:0] addr; logic [127:0] wl; logic [31:0] data; int lat;
        issue(1'b0, WORD, 32'h0000_0104, 32'h0);
        mem_accept("cold", we, addr, wl);
        checks++;
        if (we !== 1'b0 || addr !== 32'h0000_0100) begin
            errors++;
            $display("[TB] FAIL cold_refill_req: we=%0b addr=%h, required 0/00000100", we, addr);
        end
        mem_return(L0, 2);
        wait_rsp("cold", data, lat);
        checks++;
        if (data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL cold_load_data: got %h, required deadbeef", data);
        end
        issue(1'b0, WORD, 32'h0000_0104, 32'h0);
        checks++;
        if (mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL repeat_no_memreq: got %0b, required 0", mem_req_valid_o);
        end
        wait_rsp("repeat", data, lat);
        checks++;
        if (lat != 2 || data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL repeat_hit: latency=%0d data=%h, required 2/deadbeef", lat, data);
        end
    endtask

    task automatic test_subword();
        logic [31:0] data; int lat;
        issue(1'b1, BYTE, 32'h0000_0105, 32'h0000_00AB);
        wait_rsp("byte_store", data, lat);
        checks++;
        if (lat != 2 || data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL byte_store_hit: latency=%0d data=%h, required 2/00000000", lat, data);
        end
        issue(1'b0, WORD, 32'h0000_0104, 32'h0);
        wait_rsp("word_after_byte", data, lat);
        checks++;
        if (data !== 32'hDEAD_ABEF) begin
            errors++;
            $display("[TB] FAIL word_after_byte: got %h, required deadabef", data);
        end
        issue(1'b0, HALF, 32'h0000_0106, 32'h0);
        wait_rsp("half_load", data, lat);
        checks++;
        if (data !== 32'h0000_DEAD) begin
            errors++;
            $display("[TB] FAIL half_load: got %h, required 0000dead", data);
        end
        issue(1'b0, HALF, 32'h0000_0107, 32'h0);
        wait_rsp("half_unaligned", data, lat);
        checks++;
        if (data !== 32'h0000_DEAD) begin
            errors++;
            $display("[TB] FAIL half_unaligned: got %h, required 0000dead", data);
        end
        issue(1'b0, BYTE, 32'h0000_0105, 32'h0);
        wait_rsp("byte_load", data, lat);
        checks++;
        if (data !== 32'h0000_00AB) begin
            errors++;
            $display("[TB] FAIL byte_load: got %h, required 000000ab", data);
        end
    endtask

    task automatic test_eviction();
        logic we; logic [31:0] addr; logic [127:0] wl; logic [31:0] data; int lat;
        issue(1'b1, WORD, 32'h0000_1108, 32'h1234_5678);
        mem_accept("fill_way1", we, addr, wl);
        checks++;
        if (we !== 1'b0 || addr !== 32'h0000_1100) begin
            errors++;
            $display("[TB] FAIL fill_way1_req: we=%0b addr=%h, required 0/00001100", we, addr);
        end
        mem_return(L1, 0);
        wait_rsp("store_miss", data, lat);
        checks++;
        if (data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL store_miss_rdata: got %h, required 00000000", data);
        end
        issue(1'b0, WORD, 32'h0000_2100, 32'h0);
        mem_accept("evict0_wb", we, addr, wl);
        checks++;
        if (we !== 1'b1 || addr !== 32'h0000_0100 || wl !== WB0) begin
            errors++;
            $display("[TB] FAIL evict0_wb: we=%0b addr=%h line=%h, required 1/00000100/%h",
                     we, addr, wl, WB0);
        end
        mem_accept("evict0_rf", we, addr, wl);
        checks++;
        if (we !== 1'b0 || addr !== 32'h0000_2100) begin
            errors++;
            $display("[TB] FAIL evict0_rf: we=%0b addr=%h, required 0/00002100", we, addr);
        end
        mem_return(L2, 1);
        wait_rsp("evict0", data, lat);
        checks++;
        if (data !== 32'hBBBB_0000) begin
            errors++;
            $display("[TB] FAIL evict0_data: got %h, required bbbb0000", data);
        end
    endtask

    // Second conflict evicts way1; memory stalls both requests and delays the refill.
    task automatic test_backpressure();
        logic [31:0] data; int lat; int n = 0; int pulses = 0;
        issue(1'b0, WORD, 32'h0000_310C, 32'h0);
        while (!mem_req_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b1 ||
                mem_req_addr_o !== 32'h0000_1100 || mem_wline_o !== WB1 ||
                req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wb_stall: v=%0b we=%0b addr=%h line=%h rdy=%0b rsp=%0b, required 1/1/00001100/%h/0/0",
                         mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_wline_o,
                         req_ready_o, rsp_valid_o, WB1);
            end
            @(negedge clk_i);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b0 ||
                mem_req_addr_o !== 32'h0000_3100 || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rf_stall: v=%0b we=%0b addr=%h rdy=%0b rsp=%0b, required 1/0/00003100/0/0",
                         mem_req_valid_o, mem_req_we_o, mem_req_addr_o, req_ready_o, rsp_valid_o);
            end
            @(negedge clk_i);
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (rsp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rf_wait_quiet: rsp=%0b memreq=%0b, required 0/0", rsp_valid_o, mem_req_valid_o);
            end
            @(negedge clk_i);
        end
        mem_return(L3, 0);
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid_o) begin
                pulses++;
                data = rsp_rdata_o;
            end
            @(negedge clk_i);
        end
        checks++;
        if (pulses != 1 || data !== 32'hCCCC_0003) begin
            errors++;
            $display("[TB] FAIL delayed_refill_rsp: pulses=%0d data=%h, required 1/cccc0003", pulses, data);
        end
        lat = 0;
    endtask

    task automatic test_reset_mid_refill();
        logic we; logic [31:0] addr; logic [127:0] wl; logic [31:0] data; int lat;
        issue(1'b0, WORD, 32'h0000_4100, 32'h0);
        mem_accept("pre_reset", we, addr, wl);
        checks++;
        if (we !== 1'b0 || addr !== 32'h0000_4100) begin
            errors++;
            $display("[TB] FAIL pre_reset_rf: we=%0b addr=%h, required 0/00004100", we, addr);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: rsp=%0b data=%h memreq=%0b, required 0/0/0",
                     rsp_valid_o, rsp_rdata_o, mem_req_valid_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_return(L3, 0);
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_rsp_ignored: rsp=%0b rdy=%0b memreq=%0b, required 0/1/0",
                     rsp_valid_o, req_ready_o, mem_req_valid_o);
        end
        issue(1'b0, WORD, 32'h0000_4100, 32'h0);
        mem_accept("post_reset", we, addr, wl);
        checks++;
        if (we !== 1'b0 || addr !== 32'h0000_4100) begin
            errors++;
            $display("[TB] FAIL post_reset_miss: we=%0b addr=%h, required 0/00004100", we, addr);
        end
        mem_return(L4, 0);
        wait_rsp("post_reset", data, lat);
        checks++;
        if (data !== 32'hDDDD_0000) begin
            errors++;
            $display("[TB] FAIL post_reset_data: got %h, required dddd0000", data);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0; int rsp = 0; int dup = 0; logic prev = 1'b0;
        @(negedge clk_i);
        req_we_i    = 1'b0;
        req_dtype_i = WORD;
        req_addr_i  = 32'h0000_4104;
        req_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready_o) acc++;
            if (rsp_valid_o) begin
                rsp++;
                if (prev) dup++;
                checks++;
                if (rsp_rdata_o !== 32'hDDDD_0001) begin
                    errors++;
                    $display("[TB] FAIL b2b_data: got %h, required dddd0001", rsp_rdata_o);
                end
            end
            prev = rsp_valid_o;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid_o) begin
                rsp++;
                if (prev) dup++;
            end
            prev = rsp_valid_o;
            @(negedge clk_i);
        end
        checks++;
        if (acc != 4 || rsp != acc || dup != 0) begin
            errors++;
            $display("[TB] FAIL b2b_handshake: accepts=%0d responses=%0d dups=%0d, required 4/4/0", acc, rsp, dup);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting segre_assoc_cache bench");
        test_reset();
        test_cold_load();
        test_subword();
        test_eviction();
        test_backpressure();
        test_reset_mid_refill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
